// File: rtl/snake_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snake_sequencer
// Purpose  : Control sequencer for an LED-matrix snake game. Latches button
//            presses, paces the external game datapath with a tick
//            handshake, and multiplexes the pixel map onto a row-scanned
//            LED matrix between game ticks.
//
// Ports    : clka            - sole clock, all state changes on posedge
//            restart         - synchronous active-high reset
//            direction_in    - buttons {right, left, down, up}, active-high
//            logic_done      - datapath finished its board update
//            prng_done       - datapath finished placing new food
//            collision       - game-over flag, meaningful with logic_done
//            led_array       - pixel map, row r at [r*COLS +: COLS]
//            game_state      - INIT=0, RUN=1, STOP=2
//            direction_state - UP=0, DOWN=1, LEFT=2, RIGHT=3
//            execution_state - CHECK=0, INPUT=1, WAIT_LOGIC=2, UPDATE=3,
//                              WAIT_PRNG=4, DISPLAY=5
//            to_logic        - bit0 LOGIC_TICK, bit1 NO_UPDATE
//            row_cathode     - one-cold row enable (registered)
//            column_anode    - active-high column drive (registered)
//
// Options  : SNAKE_REVERSE_LOCK_EN - when defined, a pending press that
//            reverses the snake onto itself is dropped instead of applied.
//
// Revision : 1.0 - initial release
// ============================================================================
module snake_sequencer #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DWELL  = 4,
    parameter int FRAMES = 1
) (
    input  logic                 clka,
    input  logic                 restart,
    input  logic [3:0]           direction_in,
    input  logic                 logic_done,
    input  logic                 prng_done,
    input  logic                 collision,
    input  logic [ROWS*COLS-1:0] led_array,
    output logic [1:0]           game_state,
    output logic [1:0]           direction_state,
    output logic [2:0]           execution_state,
    output logic [1:0]           to_logic,
    output logic [ROWS-1:0]      row_cathode,
    output logic [COLS-1:0]      column_anode
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_EX_CHECK      = 3'd0;
    localparam logic [2:0] c_EX_INPUT      = 3'd1;
    localparam logic [2:0] c_EX_WAIT_LOGIC = 3'd2;
    localparam logic [2:0] c_EX_UPDATE     = 3'd3;
    localparam logic [2:0] c_EX_WAIT_PRNG  = 3'd4;
    localparam logic [2:0] c_EX_DISPLAY    = 3'd5;

    localparam logic [1:0] c_GS_INIT = 2'd0;
    localparam logic [1:0] c_GS_RUN  = 2'd1;
    localparam logic [1:0] c_GS_STOP = 2'd2;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    // Counter widths never drop below one bit so DWELL=1 / FRAMES=1 work.
    localparam int c_ROW_W   = (ROWS   > 1) ? $clog2(ROWS)   : 1;
    localparam int c_DWELL_W = (DWELL  > 1) ? $clog2(DWELL)  : 1;
    localparam int c_FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(ROWS - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAMES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [1:0]           r_game;
    logic [1:0]           r_dir;
    logic                 r_pend_vld;
    logic [1:0]           r_pend_dir;
    logic                 r_collision;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_FRAME_W-1:0] r_frame;
    logic [ROWS-1:0]      r_cathode;
    logic [COLS-1:0]      r_anode;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                 w_press_vld;
    logic [1:0]           w_press_dir;
    logic                 w_reverse;
    logic                 w_dir_ok;
    logic                 w_scan_last;
    logic [2:0]           w_state_nxt;
    logic [1:0]           w_game_nxt;
    logic [1:0]           w_dir_nxt;
    logic                 w_consume;
    logic [1:0]           w_to_logic;
    logic [ROWS-1:0]      w_cathode_nxt;
    logic [COLS-1:0]      w_rows [ROWS];
    logic [COLS-1:0]      w_anode_nxt;

    // ------------------------------------------------------------------------
    // Button decode: only a single held button counts as a press.
    // ------------------------------------------------------------------------
    assign w_press_vld = $onehot(direction_in);

    always_comb begin
        w_press_dir = c_DIR_UP;
        case (direction_in)
            4'b0010: w_press_dir = c_DIR_DOWN;
            4'b0100: w_press_dir = c_DIR_LEFT;
            4'b1000: w_press_dir = c_DIR_RIGHT;
            default: w_press_dir = c_DIR_UP;
        endcase
    end

    // Opposite directions differ only in bit0 (UP/DOWN, LEFT/RIGHT).
    assign w_reverse = (r_pend_dir == (r_dir ^ 2'b01));

`ifdef SNAKE_REVERSE_LOCK_EN
    assign w_dir_ok = !w_reverse;
`else
    assign w_dir_ok = 1'b1;
    // Reversal detection only matters when the lock is built in.
    logic w_unused_reverse;
    assign w_unused_reverse = w_reverse;
`endif

    // ------------------------------------------------------------------------
    // Display scan bookkeeping
    // ------------------------------------------------------------------------
    assign w_scan_last = (r_dwell == c_DWELL_LAST) &&
                         (r_row   == c_ROW_LAST)   &&
                         (r_frame == c_FRAME_LAST);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_decode
            assign w_rows[gi]        = led_array[gi*COLS +: COLS];
            assign w_cathode_nxt[gi] = (r_row != c_ROW_W'(gi));
        end
    endgenerate

    assign w_anode_nxt = w_rows[r_row];

    // ------------------------------------------------------------------------
    // Execution FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_game_nxt  = r_game;
        w_dir_nxt   = r_dir;
        w_consume   = 1'b0;
        w_to_logic  = 2'b00;

        case (r_state)
            c_EX_CHECK: begin
                if (r_game == c_GS_INIT) begin
                    // The first press starts the game; until then just idle
                    // on the display scan.
                    if (r_pend_vld) begin
                        w_game_nxt  = c_GS_RUN;
                        w_state_nxt = c_EX_INPUT;
                    end else begin
                        w_state_nxt = c_EX_DISPLAY;
                    end
                end else begin
                    w_state_nxt = c_EX_INPUT;
                end
            end

            c_EX_INPUT: begin
                // One-cycle tick; NO_UPDATE tells the datapath the game is
                // over so it should not move the snake.
                w_to_logic = {(r_game == c_GS_STOP), 1'b1};
                w_consume  = 1'b1;
                if ((r_game == c_GS_RUN) && r_pend_vld && w_dir_ok) begin
                    w_dir_nxt = r_pend_dir;
                end
                w_state_nxt = c_EX_WAIT_LOGIC;
            end

            c_EX_WAIT_LOGIC: begin
                if (logic_done) begin
                    w_state_nxt = (r_game == c_GS_STOP) ? c_EX_DISPLAY
                                                        : c_EX_UPDATE;
                end
            end

            c_EX_UPDATE: begin
                if (r_collision) begin
                    w_game_nxt = c_GS_STOP;
                end
                w_state_nxt = c_EX_WAIT_PRNG;
            end

            c_EX_WAIT_PRNG: begin
                if (prng_done) begin
                    w_state_nxt = c_EX_DISPLAY;
                end
            end

            c_EX_DISPLAY: begin
                if (w_scan_last) begin
                    w_state_nxt = c_EX_CHECK;
                end
            end

            default: begin
                w_state_nxt = c_EX_CHECK;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Execution FSM: state registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (restart) begin
            r_state <= c_EX_CHECK;
            r_game  <= c_GS_INIT;
            r_dir   <= c_DIR_RIGHT;
        end else begin
            r_state <= w_state_nxt;
            r_game  <= w_game_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Pending press: a fresh press always overwrites (last press wins), even
    // in the cycle the previous one is consumed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (restart) begin
            r_pend_vld <= 1'b0;
            r_pend_dir <= c_DIR_UP;
        end else if (w_press_vld) begin
            r_pend_vld <= 1'b1;
            r_pend_dir <= w_press_dir;
        end else if (w_consume) begin
            r_pend_vld <= 1'b0;
        end
    end

    // Collision is only meaningful alongside logic_done, so capture it there
    // for use in the following UPDATE cycle.
    always_ff @(posedge clka) begin
        if (restart) begin
            r_collision <= 1'b0;
        end else if ((r_state == c_EX_WAIT_LOGIC) && logic_done) begin
            r_collision <= collision;
        end
    end

    // ------------------------------------------------------------------------
    // Scan counters: dwell -> row -> frame, held at zero outside DISPLAY so
    // every scan starts on row 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (restart || (r_state != c_EX_DISPLAY)) begin
            r_dwell <= '0;
            r_row   <= '0;
            r_frame <= '0;
        end else if (r_dwell != c_DWELL_LAST) begin
            r_dwell <= r_dwell + c_DWELL_W'(1);
        end else begin
            r_dwell <= '0;
            if (r_row != c_ROW_LAST) begin
                r_row <= r_row + c_ROW_W'(1);
            end else begin
                r_row <= '0;
                if (r_frame != c_FRAME_LAST) begin
                    r_frame <= r_frame + c_FRAME_W'(1);
                end else begin
                    r_frame <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display drivers: registered one cycle behind the scan position and
    // blanked once the FSM has left DISPLAY.
    // ------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (restart || (r_state != c_EX_DISPLAY)) begin
            r_cathode <= '1;
            r_anode   <= '0;
        end else begin
            r_cathode <= w_cathode_nxt;
            r_anode   <= w_anode_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign game_state      = r_game;
    assign direction_state = r_dir;
    assign execution_state = r_state;
    assign to_logic        = w_to_logic;
    assign row_cathode     = r_cathode;
    assign column_anode    = r_anode;

endmodule

`default_nettype wire

// File: doc/snake_sequencer.md
SNAKE_SEQUENCER -- requirements
Module: snake_sequencer

Interface
REQ-001 Parameter ROWS, 8, display rows (2..16).
REQ-002 Parameter COLS, 8, display columns (2..16).
REQ-003 Parameter DWELL, 4, clka cycles each row is lit per scan.
REQ-004 Parameter FRAMES, 1, full display scans per game tick.
REQ-005 Port clka  in  1  sole clock; all state updates on posedge.
REQ-006 Port restart  in  1  reset, synchronous, active-high.
REQ-007 Port direction_in  in  4  buttons, active-high: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-008 Port logic_done  in  1  datapath finished board update.
REQ-009 Port prng_done  in  1  datapath finished new food position.
REQ-010 Port collision  in  1  game-over flag from datapath; valid only while logic_done=1.
REQ-011 Port led_array  in  ROWS*COLS  pixel map; row r is bits [r*COLS +: COLS].
REQ-012 Port game_state  out  2  INIT=0, RUN=1, STOP=2.
REQ-013 Port direction_state  out  2  UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-014 Port execution_state  out  3  CHECK=0, INPUT=1, WAIT_LOGIC=2, UPDATE=3, WAIT_PRNG=4, DISPLAY=5.
REQ-015 Port to_logic  out  2  bit0 LOGIC_TICK, bit1 NO_UPDATE.
REQ-016 Port row_cathode  out  ROWS  one-cold row enable.
REQ-017 Port column_anode  out  COLS  active-high column drive.

Function
REQ-018 direction_in with exactly one bit set is a valid press; zero or multiple bits set are ignored.
REQ-019 Valid presses are latched every cycle into a pending register (last press wins); pending is cleared when consumed in INPUT.
REQ-020 CHECK: INIT with pending -> game_state RUN, go INPUT; INIT without pending -> DISPLAY; RUN or STOP -> INPUT.
REQ-021 INPUT: LOGIC_TICK high exactly one cycle; NO_UPDATE high in same cycle iff game_state=STOP; in RUN, direction_state takes pending value when pending exists; next WAIT_LOGIC.
REQ-022 WAIT_LOGIC: hold until logic_done=1; then STOP -> DISPLAY, otherwise UPDATE.
REQ-023 UPDATE (one cycle): collision=1 (sampled with logic_done) -> game_state STOP; next WAIT_PRNG.
REQ-024 WAIT_PRNG: hold until prng_done=1, then DISPLAY.
REQ-025 DISPLAY: scan rows 0..ROWS-1, each for DWELL cycles, repeated FRAMES times; exactly ROWS*DWELL*FRAMES cycles, then CHECK.
REQ-026 Display outputs registered: during DISPLAY cycle k, row r active -> next cycle row_cathode bit r=0 (others 1), column_anode=led_array row r sampled at k.
REQ-027 Outside DISPLAY, display outputs blank the cycle after leaving: row_cathode all 1, column_anode 0.
REQ-028 Counters wrap row index ROWS-1 -> 0 and dwell DWELL-1 -> 0; no intermediate state skips a row.
REQ-029 logic_done/prng_done outside their wait states are ignored; STOP persists until restart.

Reset
REQ-030 restart=1 at posedge: game_state INIT, direction_state RIGHT, execution_state CHECK, to_logic 0, row_cathode all 1, column_anode 0, pending cleared, counters 0.
REQ-031 restart overrides all other inputs in any state, including mid-DISPLAY and mid-wait; a press in the same cycle is discarded.

Configuration
REQ-032 Macro SNAKE_REVERSE_LOCK_EN defined: in INPUT, a pending direction opposite to direction_state (UP/DOWN, LEFT/RIGHT) is discarded and direction_state kept.
REQ-033 Macro SNAKE_REVERSE_LOCK_EN undefined: any pending direction is applied unconditionally.

Verification (ROWS=8, COLS=8, DWELL=2, FRAMES=1)
REQ-034 restart 1 cycle, no presses -> game_state 0, execution CHECK->DISPLAY, 16 DISPLAY cycles, then CHECK; to_logic never high.
REQ-035 INIT, direction_in=4'b0001 one cycle -> at CHECK game_state 1, INPUT pulses to_logic=2'b01, direction_state 0.
REQ-036 RUN, logic_done with collision=1 -> UPDATE sets game_state 2; next tick to_logic=2'b11, WAIT_LOGIC -> DISPLAY skipping WAIT_PRNG.
REQ-037 led_array row 3 = 8'hA5 -> while row 3 lit, row_cathode=8'hF7, column_anode=8'hA5 for 2 cycles.
REQ-038 direction_state RIGHT, press LEFT (4'b0100): macro defined -> stays 3; undefined -> becomes 2; press 4'b0011 -> ignored.
REQ-039 restart asserted mid-DISPLAY and during WAIT_PRNG -> all outputs equal REQ-030 values next cycle.
